// File: rtl/sd_spi_master_pkg.sv
// sd_spi_master_pkg: FSM state encoding and constants shared by the SD SPI
// master and its optional CRC7 helper.
package sd_spi_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_t;

  // MOSI level driven between bytes (card sees all-ones filler)
  localparam logic       SD_IDLE_DOUT = 1'b1;

  // CRC7 generator polynomial x^7 + x^3 + 1 (x^7 implicit)
  localparam logic [6:0] CRC7_POLY    = 7'h09;

endpackage

// File: rtl/sd_spi_master_crc7.sv
// sd_crc7: bit-serial CRC7 accumulator used to build SD command CRC bytes.
// clr has priority over en; the register starts at zero.
module sd_crc7
  import sd_spi_master_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic       fb;

  // Next CRC: shift in one message bit, fold feedback through the polynomial
  always_comb begin
    crc_d = crc_q;
    fb    = 1'b0;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      fb    = bit_in ^ crc_q[6];
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

  // CRC register
  always_ff @(posedge clk) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_spi_master.sv
// sd_spi_master: byte-wide SPI mode-0 master for the SD card socket.
// Each accepted start shifts one byte out MSB first on sd_dout while shifting
// sd_din in; sd_clk idles low, is raised at the end of each LOW phase (where
// sd_din is sampled) and lowered at the end of each HIGH phase (where the next
// MOSI bit is presented). done is asserted during the last HIGH cycle, and
// rx_data shows the received byte from that cycle onward.
// Optional build macro SD_SPI_CRC7_EN adds crc_clr/crc7 and a CRC7 over the
// transmitted bits.
module sd_spi_master
  import sd_spi_master_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  input  logic       cs_wr,
  input  logic       cs_val,
  output logic       sd_cs_n,
  output logic       sd_clk,
  output logic       sd_dout,
  input  logic       sd_din
`ifdef SD_SPI_CRC7_EN
  ,
  input  logic       crc_clr,
  output logic [6:0] crc7
`endif
);

  localparam int             DW       = $clog2(DIV + 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);

  spi_state_t    state_q,   state_d;
  logic [DW-1:0] div_q,     div_d;
  logic [2:0]    bit_q,     bit_d;
  logic          sclk_q,    sclk_d;
  logic          dout_q,    dout_d;
  logic          cs_n_q,    cs_n_d;
  logic [7:0]    tx_sh_q,   tx_sh_d;
  logic [7:0]    rx_sh_q,   rx_sh_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          done_c;

  // Next-state logic: phase timing, bit shifting and CS writes (idle only)
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sclk_d    = sclk_q;
    dout_d    = dout_q;
    cs_n_d    = cs_n_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_byte_d = rx_byte_q;
    done_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_wr) cs_n_d = cs_val;
        if (start) begin
          state_d = ST_LOW;
          div_d   = '0;
          bit_d   = '0;
          tx_sh_d = tx_data;
          dout_d  = tx_data[7];
        end
      end
      ST_LOW: begin
        if (div_q == DIV_LAST) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], sd_din};
          div_d   = '0;
          state_d = ST_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (div_q == DIV_LAST) begin
          sclk_d = 1'b0;
          div_d  = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rx_byte_d = rx_sh_q;
            done_c    = 1'b1;
            dout_d    = SD_IDLE_DOUT;
            state_d   = ST_IDLE;
          end else begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            dout_d  = tx_sh_q[6];
            state_d = ST_LOW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b0;
        dout_d  = SD_IDLE_DOUT;
      end
    endcase
  end

  // State and datapath registers; reset aborts any byte in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      dout_q    <= SD_IDLE_DOUT;
      cs_n_q    <= 1'b1;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_byte_q <= 8'hFF;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      dout_q    <= dout_d;
      cs_n_q    <= cs_n_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  // The completed byte is already in the shift register during the done cycle
  assign rx_data = done_c ? rx_sh_q : rx_byte_q;
  assign done    = done_c;
  assign busy    = (state_q != ST_IDLE);
  assign sd_cs_n = cs_n_q;
  assign sd_clk  = sclk_q;
  assign sd_dout = dout_q;

`ifdef SD_SPI_CRC7_EN
  // Rising-edge event: the bit on sd_dout is the one the card samples now
  logic bit_rise;
  assign bit_rise = (state_q == ST_LOW) && (div_q == DIV_LAST);

  sd_crc7 u_crc7 (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (bit_rise),
    .bit_in (dout_q),
    .crc    (crc7)
  );
`endif

endmodule
